// File: rtl/tdm_pkg.sv
// tdm_pkg: definitions shared by the TDM receive demultiplexer and the
// companion TDM transmitter (slot count, slot-index type, lock-state enum).
package tdm_pkg;

  localparam int NSLOT  = 4;
  localparam int SLOT_W = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  // Index of the final slot in a frame; the slot counter wraps after it.
  localparam slot_t LAST_SLOT = slot_t'(NSLOT - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: bundles the TDM line and the reassembled-frame outputs.
//   din/sync             : TDM line and slot-0 strobe (driven by the line side)
//   ch                   : reassembled frame, slot k at ch[k*DW +: DW]
//   frame_valid          : one-cycle pulse when ch updates
//   locked / sync_err    : alignment status and one-cycle sync error pulse
// Modports: master = line source / frame consumer, slave = demultiplexer.
interface tdm_demux4_if
  import tdm_pkg::*;
#(
  parameter int DW = 1
);

  logic [DW-1:0]       din;
  logic                sync;
  logic [NSLOT*DW-1:0] ch;
  logic                frame_valid;
  logic                locked;
  logic                sync_err;

  modport master (
    output din, sync,
    input  ch, frame_valid, locked, sync_err
  );

  modport slave (
    input  din, sync,
    output ch, frame_valid, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit mod-NSLOT slot counter, shared with the transmitter's
// select generator.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear to 0
//   load1    : synchronous load of 1 (the cycle carrying slot 0 has just passed)
//   en       : advance by one, wrapping LAST_SLOT -> 0
//   slot     : registered slot index
// Priority: rst/clr > load1 > en.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  load1,
  input  logic  en,
  output slot_t slot
);

  slot_t slot_r;

  // Slot index register with clear, load-to-1 and wrapping increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slot_r <= 2'd0;
    end else if (load1) begin
      slot_r <= 2'd1;
    end else if (en) begin
      slot_r <= (slot_r == LAST_SLOT) ? 2'd0 : slot_r + 2'd1;
    end else begin
      slot_r <= slot_r;
    end
  end

  assign slot = slot_r;

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4:1 TDM link. Samples one slot per clock,
// aligns to the frame with the sync strobe, and emits each complete frame as
// a registered parallel word with a one-cycle frame_valid pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tdm_demux4_if.slave (din, sync in; ch, frame_valid, locked,
//              sync_err out); all outputs are registered
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

  state_t              state_r;
  logic [DW-1:0]       shadow_r [0:NSLOT-2];
  logic [NSLOT*DW-1:0] ch_r;
  logic                frame_valid_r;
  logic                locked_r;
  logic                sync_err_r;

  slot_t               slot_s;
  logic                clr_s;
  logic                load1_s;
  logic                en_s;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .load1 (load1_s),
    .en    (en_s),
    .slot  (slot_s)
  );

  // Slot counter control: any accepted sync makes the next cycle slot 1; a
  // missing sync parks the counter at 0 for the return to HUNT.
  always_comb begin
    clr_s   = 1'b0;
    load1_s = 1'b0;
    en_s    = 1'b0;
    case (state_r)
      HUNT: begin
        if (bus.sync) begin
          load1_s = 1'b1;
        end else begin
          clr_s = 1'b1;
        end
      end
      LOCKED: begin
        if (bus.sync) begin
          load1_s = 1'b1;
        end else if (slot_s == 2'd0) begin
          clr_s = 1'b1;
        end else begin
          en_s = 1'b1;
        end
      end
      default: begin
        clr_s = 1'b1;
      end
    endcase
  end

  // Lock FSM, shadow capture and registered frame outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= HUNT;
      shadow_r[0]   <= '0;
      shadow_r[1]   <= '0;
      shadow_r[2]   <= '0;
      ch_r          <= '0;
      frame_valid_r <= 1'b0;
      locked_r      <= 1'b0;
      sync_err_r    <= 1'b0;
    end else begin
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
      case (state_r)
        HUNT: begin
          if (bus.sync) begin
            shadow_r[0] <= bus.din;
            state_r     <= LOCKED;
            locked_r    <= 1'b1;
          end
        end
        LOCKED: begin
          if (bus.sync) begin
            // Sync anywhere but slot 0 (including slot 3) restarts the frame
            // here; the partial frame is dropped.
            if (slot_s != 2'd0) begin
              sync_err_r <= 1'b1;
            end
            shadow_r[0] <= bus.din;
          end else begin
            case (slot_s)
              2'd0: begin
                sync_err_r <= 1'b1;
                locked_r   <= 1'b0;
                state_r    <= HUNT;
              end
              2'd1: shadow_r[1] <= bus.din;
              2'd2: shadow_r[2] <= bus.din;
              2'd3: begin
                ch_r          <= {bus.din, shadow_r[2], shadow_r[1], shadow_r[0]};
                frame_valid_r <= 1'b1;
              end
              default: begin
                state_r <= HUNT;
              end
            endcase
          end
        end
        default: begin
          state_r  <= HUNT;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ch          = ch_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.locked      = locked_r;
  assign bus.sync_err    = sync_err_r;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed self-checking bench for tdm_demux4 with DW=1.
// Inputs change 1 ns after each rising edge; outputs are sampled there too,
// so each sample reflects the edge just taken.
module tb_tdm_demux4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tdm_demux4_if #(.DW(1)) bus ();

  tdm_demux4 #(.DW(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one slot and advance past the next rising edge.
  task automatic tick(input logic d, input logic s);
    bus.din  = d;
    bus.sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    checks++; if (bus.ch !== 4'b0000) begin errors++; $display("FAIL reset_ch got %b want 0000", bus.ch); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", bus.frame_valid); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", bus.locked); end
    checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b want 0", bus.sync_err); end
    rst = 1'b0;
  endtask

  task automatic test_hunt();
    logic [3:0] w;
    for (int i = 0; i < 10; i++) begin
      tick(1'(i % 2), 1'b0);
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL hunt_locked cyc %0d got %b want 0", i, bus.locked); end
      checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL hunt_fv cyc %0d got %b want 0", i, bus.frame_valid); end
    end
    w = 4'b1101;  // slots 0..3 carry 1,0,1,1
    for (int k = 0; k < 4; k++) begin
      tick(w[k], (k == 0) ? 1'b1 : 1'b0);
      checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL hunt_lock slot %0d got %b want 1", k, bus.locked); end
      checks++; if (bus.frame_valid !== (k == 3)) begin errors++; $display("FAIL hunt_frame_fv slot %0d got %b want %b", k, bus.frame_valid, (k == 3)); end
    end
    checks++; if (bus.ch !== 4'b1101) begin errors++; $display("FAIL hunt_ch got %b want 1101", bus.ch); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] frames [3];
    logic [3:0] prev;
    frames[0] = 4'b1011;  // slots 1,1,0,1
    frames[1] = 4'b0100;  // slots 0,0,1,0
    frames[2] = 4'b1111;
    prev = 4'b1101;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        tick(frames[f][k], (k == 0) ? 1'b1 : 1'b0);
        checks++; if (bus.frame_valid !== (k == 3)) begin errors++; $display("FAIL b2b_fv frame %0d slot %0d got %b want %b", f, k, bus.frame_valid, (k == 3)); end
        checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL b2b_sync_err frame %0d slot %0d got %b want 0", f, k, bus.sync_err); end
        checks++; if (bus.ch !== ((k == 3) ? frames[f] : prev)) begin errors++; $display("FAIL b2b_ch frame %0d slot %0d got %b want %b", f, k, bus.ch, (k == 3) ? frames[f] : prev); end
      end
      prev = frames[f];
    end
  endtask

  task automatic test_early_sync();
    // Partial frame, then sync again at slot 2 (din=1 becomes new slot 0).
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    checks++; if (bus.sync_err !== 1'b1) begin errors++; $display("FAIL early_sync_err got %b want 1", bus.sync_err); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL early_fv got %b want 0", bus.frame_valid); end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL early_locked got %b want 1", bus.locked); end
    checks++; if (bus.ch !== 4'b1111) begin errors++; $display("FAIL early_ch_hold got %b want 1111", bus.ch); end
    tick(1'b0, 1'b0);
    checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL early_err_pulse got %b want 0", bus.sync_err); end
    tick(1'b1, 1'b0);
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL early_fv2 got %b want 0", bus.frame_valid); end
    tick(1'b0, 1'b0);
    checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL early_realign_fv got %b want 1", bus.frame_valid); end
    checks++; if (bus.ch !== 4'b0101) begin errors++; $display("FAIL early_realign_ch got %b want 0101", bus.ch); end
    // Sync coinciding with slot 3: no frame, treated as a new slot 0 (din=1).
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    checks++; if (bus.sync_err !== 1'b1) begin errors++; $display("FAIL slot3_sync_err got %b want 1", bus.sync_err); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL slot3_fv got %b want 0", bus.frame_valid); end
    checks++; if (bus.ch !== 4'b0101) begin errors++; $display("FAIL slot3_ch_hold got %b want 0101", bus.ch); end
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL slot3_next_fv got %b want 1", bus.frame_valid); end
    checks++; if (bus.ch !== 4'b0111) begin errors++; $display("FAIL slot3_next_ch got %b want 0111", bus.ch); end
  endtask

  task automatic test_missing_sync();
    logic [3:0] w;
    tick(1'b1, 1'b0);  // slot 0 without sync
    checks++; if (bus.sync_err !== 1'b1) begin errors++; $display("FAIL miss_sync_err got %b want 1", bus.sync_err); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL miss_locked got %b want 0", bus.locked); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL miss_fv got %b want 0", bus.frame_valid); end
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0);
      checks++; if (bus.frame_valid !== 1'b0 || bus.locked !== 1'b0 || bus.sync_err !== 1'b0) begin
        errors++; $display("FAIL miss_hunt cyc %0d got fv=%b locked=%b err=%b want 0 0 0", i, bus.frame_valid, bus.locked, bus.sync_err);
      end
    end
    checks++; if (bus.ch !== 4'b0111) begin errors++; $display("FAIL miss_ch_hold got %b want 0111", bus.ch); end
    w = 4'b0110;  // slots 0,1,1,0
    for (int k = 0; k < 4; k++) begin
      tick(w[k], (k == 0) ? 1'b1 : 1'b0);
      checks++; if (bus.frame_valid !== (k == 3)) begin errors++; $display("FAIL miss_relock_fv slot %0d got %b want %b", k, bus.frame_valid, (k == 3)); end
    end
    checks++; if (bus.ch !== 4'b0110) begin errors++; $display("FAIL miss_relock_ch got %b want 0110", bus.ch); end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL miss_relock_locked got %b want 1", bus.locked); end
  endtask

  task automatic test_reset_mid_frame();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b0);  // slot 2 under reset
    rst = 1'b0;
    checks++; if (bus.ch !== 4'b0000) begin errors++; $display("FAIL midrst_ch got %b want 0000", bus.ch); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL midrst_locked got %b want 0", bus.locked); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL midrst_fv got %b want 0", bus.frame_valid); end
    for (int i = 0; i < 8; i++) begin
      tick(1'(i % 3 == 0), 1'b0);
      checks++; if (bus.frame_valid !== 1'b0 || bus.locked !== 1'b0) begin
        errors++; $display("FAIL midrst_stream cyc %0d got fv=%b locked=%b want 0 0", i, bus.frame_valid, bus.locked);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.din  = 1'b0;
    bus.sync = 1'b0;
    test_reset();
    test_hunt();
    test_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
